// File: rtl/main_memory_responder.sv
// Main-memory model on the shared coherence bus: fixed-latency line fills with data-bus
// arbitration, write-back acceptance, and abort when a peer cache supplies the line.
module main_memory_responder #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MEM_DEPTH_LOG2 = 10,
  parameter int unsigned RD_LATENCY     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] Address_Com,
  input  logic [DATA_WIDTH-1:0] Data_Bus_Com_in,
  output logic [DATA_WIDTH-1:0] Data_Bus_Com_out,
  output logic                  Data_Bus_Com_oe,
  input  logic                  BusRd,
  input  logic                  BusRdX,
  input  logic                  Mem_wr,
  input  logic                  Mem_oprn_abort,
  output logic                  Mem_snoop_req,
  input  logic                  Mem_snoop_gnt,
  output logic                  Data_in_Bus,
  output logic                  Mem_write_done
);

  localparam int unsigned Depth = 1 << MEM_DEPTH_LOG2;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StRdWait  = 3'd1;
  localparam logic [2:0] StRdReq   = 3'd2;
  localparam logic [2:0] StRdDrive = 3'd3;
  localparam logic [2:0] StWrDone  = 3'd4;
  localparam logic [2:0] StAbort   = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-3:0] addr_q, addr_d;
  logic [Depth-1:0]      valid_q;
  logic [DATA_WIDTH-1:0] mem [Depth];

  logic                      rd_req;
  logic                      wr_en;
  logic [MEM_DEPTH_LOG2-1:0] wr_idx;
  logic [MEM_DEPTH_LOG2-1:0] rd_idx;
  logic [DATA_WIDTH-1:0]     rd_word;
  logic                      unused_addr_lsbs;

  assign rd_req           = BusRd | BusRdX;
  assign wr_idx           = Address_Com[MEM_DEPTH_LOG2+1:2];
  assign rd_idx           = addr_q[MEM_DEPTH_LOG2-1:0];
  assign wr_en            = (state_q == StIdle) && Mem_wr && !rst;
  assign unused_addr_lsbs = ^Address_Com[1:0];

  // Unwritten words read back as their own word-aligned address.
  assign rd_word = valid_q[rd_idx] ? mem[rd_idx] : DATA_WIDTH'({addr_q, 2'b00});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    case (state_q)
      StIdle: begin
        if (Mem_wr) begin
          state_d = StWrDone;
        end else if (rd_req) begin
          if (Mem_oprn_abort) begin
            state_d = StAbort;
          end else begin
            addr_d  = Address_Com[ADDR_WIDTH-1:2];
            cnt_d   = 4'(RD_LATENCY - 1);
            state_d = StRdWait;
          end
        end
      end
      StRdWait: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        if (Mem_oprn_abort)     state_d = StAbort;
        else if (cnt_q == 4'd0) state_d = StRdReq;
      end
      StRdReq: begin
        // Abort wins over a simultaneous grant.
        if (Mem_oprn_abort)     state_d = StAbort;
        else if (Mem_snoop_gnt) state_d = StRdDrive;
      end
      StRdDrive: if (!rd_req) state_d = StIdle;
      StWrDone:  if (!Mem_wr) state_d = StIdle;
      StAbort:   if (!rd_req) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Array contents survive reset; only the valid bits are cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= Data_Bus_Com_in;
  end

  always_comb begin
    Data_Bus_Com_out = '0;
    Data_Bus_Com_oe  = 1'b0;
    Mem_snoop_req    = 1'b0;
    Data_in_Bus      = 1'b0;
    Mem_write_done   = 1'b0;
    case (state_q)
      StRdReq: Mem_snoop_req = 1'b1;
      StRdDrive: begin
        Mem_snoop_req    = 1'b1;
        Data_Bus_Com_oe  = 1'b1;
        Data_in_Bus      = 1'b1;
        Data_Bus_Com_out = rd_word;
      end
      StWrDone: Mem_write_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder: fill latency, write-back, aliasing, abort,
// grant stalls and mid-transaction reset.
module tb_main_memory_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Address_Com;
  logic [31:0] Data_Bus_Com_in;
  logic [31:0] Data_Bus_Com_out;
  logic        Data_Bus_Com_oe;
  logic        BusRd, BusRdX, Mem_wr, Mem_oprn_abort;
  logic        Mem_snoop_req, Mem_snoop_gnt, Data_in_Bus, Mem_write_done;

  int errors = 0;
  int checks = 0;
  logic seen;
  logic [31:0] outs;

  // {req, data_valid, oe, write_done}
  assign outs = {28'd0, Mem_snoop_req, Data_in_Bus, Data_Bus_Com_oe, Mem_write_done};

  always #5 clk = ~clk;

  main_memory_responder dut (
    .clk              (clk),
    .rst              (rst),
    .Address_Com      (Address_Com),
    .Data_Bus_Com_in  (Data_Bus_Com_in),
    .Data_Bus_Com_out (Data_Bus_Com_out),
    .Data_Bus_Com_oe  (Data_Bus_Com_oe),
    .BusRd            (BusRd),
    .BusRdX           (BusRdX),
    .Mem_wr           (Mem_wr),
    .Mem_oprn_abort   (Mem_oprn_abort),
    .Mem_snoop_req    (Mem_snoop_req),
    .Mem_snoop_gnt    (Mem_snoop_gnt),
    .Data_in_Bus      (Data_in_Bus),
    .Mem_write_done   (Mem_write_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; Address_Com = '0; Data_Bus_Com_in = '0;
    BusRd = 1'b0; BusRdX = 1'b0; Mem_wr = 1'b0; Mem_oprn_abort = 1'b0;
    Mem_snoop_gnt = 1'b1;
    tick(); tick();
    check("reset_outs", outs, 32'h0);
    check("reset_data", Data_Bus_Com_out, 32'h0);
    rst = 1'b0;
    tick();

    // Fill of an unwritten word, grant tied high
    Address_Com = 32'hdeadbeef; BusRd = 1'b1;
    tick();                                   // E0
    Address_Com = 32'h0;
    check("t1_e0", outs, 32'h0);
    tick(); tick(); tick();                   // E3
    check("t1_e3", outs, 32'h0);
    tick();                                   // E4
    check("t1_e4_req", outs, 32'h8);
    tick();                                   // E5
    check("t1_e5_drive", outs, 32'he);
    check("t1_data", Data_Bus_Com_out, 32'hdeadbeec);
    BusRd = 1'b0;
    tick();
    check("t1_release", outs, 32'h0);
    check("t1_data_off", Data_Bus_Com_out, 32'h0);

    // Write-back then BusRdX of the same word
    Address_Com = 32'hbabecafe; Data_Bus_Com_in = 32'hcafecafe; Mem_wr = 1'b1;
    tick();
    check("t2_wdone", outs, 32'h1);
    tick();
    check("t2_wdone_hold", outs, 32'h1);
    Mem_wr = 1'b0;
    tick();
    check("t2_wdone_drop", outs, 32'h0);
    Address_Com = 32'hbabecafc; BusRdX = 1'b1;
    tick(); tick(); tick(); tick(); tick(); tick();   // E0..E5
    check("t2_rdx_drive", outs, 32'he);
    check("t2_rdx_data", Data_Bus_Com_out, 32'hcafecafe);
    BusRdX = 1'b0;
    tick();

    // Upper address bits alias onto the same word
    Address_Com = 32'h0000_0004; Data_Bus_Com_in = 32'hcafecafb; Mem_wr = 1'b1;
    tick();
    Mem_wr = 1'b0;
    tick();
    Address_Com = 32'h0005_0004; BusRd = 1'b1;
    tick(); tick(); tick(); tick(); tick(); tick();
    check("t3_alias_data", Data_Bus_Com_out, 32'hcafecafb);
    BusRd = 1'b0;
    tick();

    // Abort sampled at E2 of a pending read
    Address_Com = 32'h0000_0100; BusRd = 1'b1;
    tick(); tick();                           // E0, E1
    Mem_oprn_abort = 1'b1;
    tick();                                   // E2
    Mem_oprn_abort = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen = seen | Mem_snoop_req | Data_in_Bus;
      tick();
    end
    check("t4_abort_quiet", {31'd0, seen}, 32'h0);
    BusRd = 1'b0;
    tick();
    // Fresh read must see full latency from IDLE; abort in RD_DRIVE is ignored
    Address_Com = 32'h0000_0040; BusRd = 1'b1;
    tick(); tick(); tick(); tick(); tick();   // E0..E4
    check("t4_req_after_abort", outs, 32'h8);
    tick();
    Mem_oprn_abort = 1'b1;
    tick();
    check("t4_drive_abort_ignored", outs, 32'he);
    check("t4_default_data", Data_Bus_Com_out, 32'h0000_0040);
    Mem_oprn_abort = 1'b0; BusRd = 1'b0;
    tick();

    // Abort together with the request in IDLE: read never starts
    BusRd = 1'b1; Mem_oprn_abort = 1'b1;
    tick();
    Mem_oprn_abort = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen = seen | Mem_snoop_req | Data_in_Bus;
      tick();
    end
    check("t4b_idle_abort_quiet", {31'd0, seen}, 32'h0);
    BusRd = 1'b0;
    tick();

    // Write and read together; grant withheld 3 cycles
    Address_Com = 32'h0000_0008; Data_Bus_Com_in = 32'h12345678;
    Mem_wr = 1'b1; BusRd = 1'b1; Mem_snoop_gnt = 1'b0;
    tick();
    check("t5_write_first", outs, 32'h1);
    Mem_wr = 1'b0;
    tick();                                   // back to IDLE, read not accepted here
    check("t5_idle", outs, 32'h0);
    tick();                                   // E0
    tick(); tick(); tick();                   // E3
    check("t5_e3_no_req", outs, 32'h0);
    tick();                                   // E4
    check("t5_e4_req", outs, 32'h8);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_stall", outs, 32'h8);
    end
    Mem_snoop_gnt = 1'b1;
    tick();
    check("t5_drive", outs, 32'he);
    check("t5_data", Data_Bus_Com_out, 32'h12345678);

    // Reset during RD_DRIVE clears outputs and valid bits
    rst = 1'b1;
    tick();
    check("t6_rst_outs", outs, 32'h0);
    check("t6_rst_data", Data_Bus_Com_out, 32'h0);
    rst = 1'b0; BusRd = 1'b0;
    tick();
    Address_Com = 32'hbabecafc; BusRd = 1'b1;
    tick(); tick(); tick(); tick(); tick(); tick();
    check("t6_drive", outs, 32'he);
    check("t6_invalid_data", Data_Bus_Com_out, 32'hbabecafc);
    BusRd = 1'b0;
    tick();
    check("t6_idle", outs, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
